il1_axi_rsp: RTL and testbench

AXI4 read-only responder serving the L1 instruction-cache refill port (AR/R channels only). It accepts one read burst at a time, sources 64-bit beats from an internal memory array after a programmable access latency, and returns them with RLAST/RRESP. It sits at the far end of the IL1 bus in simulation and FPGA builds, acting as the instruction memory behind the I-cache. A backdoor preload port fills the array.

---
 rtl/il1_axi_rsp.sv | 240 ++++++++++++++++++++++++
 tb/tb_il1_axi_rsp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/il1_axi_rsp.sv
// il1_axi_rsp: AXI4 read-only responder (AR/R channels) acting as the
// instruction memory behind the L1 I-cache. One burst at a time; 64-bit beats
// are sourced from an internal array after a programmable access latency.
// The array is filled through a backdoor preload port.
module il1_axi_rsp #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          MEM_DP  = 1024,
    parameter int          LATENCY = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [31:0]               S_ARADDR,
    input  logic [7:0]                S_ARLEN,
    input  logic [1:0]                S_ARBURST,
    input  logic                      S_ARVALID,
    output logic                      S_ARREADY,
    output logic [63:0]               S_RDATA,
    output logic [1:0]                S_RRESP,
    output logic                      S_RLAST,
    output logic                      S_RVALID,
    input  logic                      S_RREADY,
    input  logic                      pre_wen,
    input  logic [$clog2(MEM_DP)-1:0] pre_waddr,
    input  logic [63:0]               pre_wdata
);

    localparam int          IW       = $clog2(MEM_DP);
    localparam logic [31:0] MEM_DP_W = 32'(MEM_DP);
    // WAIT counts down to zero, so it is loaded with one less than the latency.
    localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [63:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic [3:0]  lat_q, lat_d;

    logic [63:0] mem_q [MEM_DP];

    logic [31:0] load_addr_s;
    logic [1:0]  load_burst_s;
    logic [28:0] word_off_s;
    logic        hit_s;
    logic [63:0] load_data_s;
    logic [1:0]  load_resp_s;
    logic        unused_s;

    // Byte-offset bits of the request address carry no meaning for 64-bit beats.
    assign unused_s = ^S_ARADDR[2:0];

    // Address of the beat following 'a' inside a burst of the given length/type.
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] mask;
        logic        wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        mask    = {20'd0, ({1'b0, len} + 9'd1), 3'b000} - 32'd1;
        case (burst)
            2'b00:   next_addr = a;
            2'b10: begin
                if (wrap_ok) begin
                    next_addr = (a & ~mask) | ((a + 32'd8) & mask);
                end else begin
                    next_addr = a + 32'd8;
                end
            end
            default: next_addr = a + 32'd8;
        endcase
    endfunction

    // Select the address/burst type of the beat that may be loaded at the next edge.
    always_comb begin
        load_addr_s  = addr_q;
        load_burst_s = burst_q;
        case (state_q)
            ST_IDLE: begin
                load_addr_s  = {S_ARADDR[31:3], 3'b000};
                load_burst_s = S_ARBURST;
            end
            ST_WAIT: begin
                load_addr_s  = addr_q;
                load_burst_s = burst_q;
            end
            ST_BURST: begin
                load_addr_s  = next_addr(addr_q, len_q, burst_q);
                load_burst_s = burst_q;
            end
            default: begin
                load_addr_s  = addr_q;
                load_burst_s = burst_q;
            end
        endcase
    end

    // Per-beat decode: out-of-window or reserved-burst beats return SLVERR with zero data.
    always_comb begin
        word_off_s = load_addr_s[31:3] - BASE[31:3];
        hit_s      = (load_addr_s >= BASE) && ({3'b000, word_off_s} < MEM_DP_W)
                     && (load_burst_s != 2'b11);
        if (hit_s) begin
            load_data_s = mem_q[word_off_s[IW-1:0]];
            load_resp_s = RESP_OKAY;
        end else begin
            load_data_s = 64'd0;
            load_resp_s = RESP_SLVERR;
        end
    end

    // Next-state and registered-output logic for the IDLE/WAIT/BURST sequencer.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (S_ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    addr_d    = load_addr_s;
                    len_d     = S_ARLEN;
                    burst_d   = S_ARBURST;
                    beat_d    = 8'd0;
                    lat_d     = LAT_LOAD;
                    if (LATENCY == 0) begin
                        state_d  = ST_BURST;
                        rvalid_d = 1'b1;
                        rdata_d  = load_data_s;
                        rresp_d  = load_resp_s;
                        rlast_d  = (S_ARLEN == 8'd0);
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d  = ST_BURST;
                    rvalid_d = 1'b1;
                    rdata_d  = load_data_s;
                    rresp_d  = load_resp_s;
                    rlast_d  = (len_q == 8'd0);
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ST_BURST: begin
                if (S_RREADY) begin
                    if (beat_q == len_q) begin
                        state_d   = ST_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        addr_d  = load_addr_s;
                        rdata_d = load_data_s;
                        rresp_d = load_resp_s;
                        rlast_d = ((beat_q + 8'd1) == len_q);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any burst in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 64'd0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            burst_q   <= 2'b00;
            beat_q    <= 8'd0;
            lat_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
        end
    end

    // Backdoor preload; a beat read at the same edge still sees the old word.
    always_ff @(posedge CLK) begin
        if (pre_wen) begin
            mem_q[pre_waddr] <= pre_wdata;
        end
    end

    assign S_ARREADY = arready_q;
    assign S_RVALID  = rvalid_q;
    assign S_RLAST   = rlast_q;
    assign S_RRESP   = rresp_q;
    assign S_RDATA   = rdata_q;

endmodule

// File: tb/tb_il1_axi_rsp.sv
// tb_il1_axi_rsp: randomized self-checking bench for il1_axi_rsp against a
// behavioural burst model (address sequence by arithmetic, shadow memory).
module tb_il1_axi_rsp;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          MEM_DP  = 64;
    localparam int          LATENCY = 2;
    localparam int          IW      = $clog2(MEM_DP);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [31:0]   S_ARADDR = 32'd0;
    logic [7:0]    S_ARLEN = 8'd0;
    logic [1:0]    S_ARBURST = 2'b01;
    logic          S_ARVALID = 1'b0;
    logic          S_ARREADY;
    logic [63:0]   S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RLAST;
    logic          S_RVALID;
    logic          S_RREADY = 1'b0;
    logic          pre_wen = 1'b0;
    logic [IW-1:0] pre_waddr = '0;
    logic [63:0]   pre_wdata = 64'd0;

    int n_chk  = 0;
    int n_pass = 0;
    logic [63:0] shadow [MEM_DP];

    il1_axi_rsp #(.BASE(BASE), .MEM_DP(MEM_DP), .LATENCY(LATENCY)) dut (
        .CLK(CLK), .RST(RST),
        .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
        .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .pre_wen(pre_wen), .pre_waddr(pre_waddr), .pre_wdata(pre_wdata)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte address of beat k of a burst, straight from the AXI burst rules.
    function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [7:0] len,
                                               input logic [1:0] burst, input int k);
        int unsigned blk, lo, off;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            blk = (int'(len) + 1) * 8;
            lo  = (start / blk) * blk;
            off = ((start - lo) + 8 * k) % blk;
            return 32'(lo + off);
        end
        return 32'(start + 8 * k);
    endfunction

    function automatic void model_beat(input logic [31:0] a, input logic [1:0] burst,
                                       output logic [63:0] d, output logic [1:0] r);
        if (burst == 2'b11 || a < BASE || ((a - BASE) / 8) >= MEM_DP) begin
            d = 64'd0;
            r = 2'b10;
        end else begin
            d = shadow[(a - BASE) / 8];
            r = 2'b00;
        end
    endfunction

    task automatic pre_write(input int idx, input logic [63:0] val);
        pre_wen   = 1'b1;
        pre_waddr = IW'(idx);
        pre_wdata = val;
        @(posedge CLK); #1;
        pre_wen = 1'b0;
        shadow[idx] = val;
    endtask

    // rmode: 0 RREADY held high, 1 RREADY raised one cycle after RVALID, 2 random stalls.
    // pre_beat >= 0 writes shadow/pre_idx at the handshake edge of that beat.
    task automatic run_burst(input logic [31:0] araddr, input logic [7:0] len, input logic [1:0] burst,
                             input int rmode, input int pre_beat, input int pre_idx,
                             input logic [63:0] pre_val);
        logic [31:0] start, a;
        logic [63:0] ed;
        logic [1:0]  er;
        int cyc, hold;
        start = araddr & 32'hFFFF_FFF8;
        cyc = 0;
        while (S_ARREADY !== 1'b1 && cyc < 20) begin @(posedge CLK); #1; cyc++; end
        check_val("arready_idle", 64'(S_ARREADY), 64'd1);
        S_ARADDR = araddr; S_ARLEN = len; S_ARBURST = burst; S_ARVALID = 1'b1;
        @(posedge CLK); #1;
        S_ARVALID = 1'b0; S_ARADDR = $urandom(); S_ARLEN = 8'($urandom()); S_ARBURST = 2'($urandom());
        check_val("arready_drop", 64'(S_ARREADY), 64'd0);
        cyc = 0;
        while (S_RVALID !== 1'b1 && cyc < 40) begin @(posedge CLK); #1; cyc++; end
        check_val("first_beat_latency", 64'(cyc), 64'(LATENCY));
        a = model_addr(start, len, burst, 0);
        model_beat(a, burst, ed, er);
        for (int k = 0; k <= int'(len); k++) begin
            check_val("rvalid", 64'(S_RVALID), 64'd1);
            check_val("rdata", S_RDATA, ed);
            check_val("rresp", 64'(S_RRESP), 64'(er));
            check_val("rlast", 64'(S_RLAST), 64'(k == int'(len)));
            hold = (rmode == 1) ? 1 : (rmode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int h = 0; h < hold; h++) begin
                S_RREADY = 1'b0;
                @(posedge CLK); #1;
                check_val("stall_rvalid", 64'(S_RVALID), 64'd1);
                check_val("stall_rdata", S_RDATA, ed);
                check_val("stall_rlast", 64'(S_RLAST), 64'(k == int'(len)));
            end
            if (k < int'(len)) begin
                a = model_addr(start, len, burst, k + 1);
                model_beat(a, burst, ed, er);
            end
            S_RREADY = 1'b1;
            if (k == pre_beat) begin
                pre_wen = 1'b1; pre_waddr = IW'(pre_idx); pre_wdata = pre_val;
            end
            @(posedge CLK); #1;
            if (k == pre_beat) begin
                pre_wen = 1'b0;
                shadow[pre_idx] = pre_val;
            end
            if (rmode != 0) S_RREADY = 1'b0;
        end
        S_RREADY = 1'b0;
        check_val("end_rvalid", 64'(S_RVALID), 64'd0);
        check_val("end_rlast", 64'(S_RLAST), 64'd0);
        check_val("end_arready", 64'(S_ARREADY), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [31:0] ra;
        logic [7:0]  rl;
        int pb;
        #2 RST = 1'b1;
        #1;
        check_val("rst_arready", 64'(S_ARREADY), 64'd0);
        check_val("rst_rvalid", 64'(S_RVALID), 64'd0);
        check_val("rst_rlast", 64'(S_RLAST), 64'd0);
        check_val("rst_rresp", 64'(S_RRESP), 64'd0);
        check_val("rst_rdata", S_RDATA, 64'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check_val("arready_before_edge", 64'(S_ARREADY), 64'd0);
        @(posedge CLK); #1;
        check_val("arready_after_release", 64'(S_ARREADY), 64'd1);

        for (int i = 0; i < MEM_DP; i++) pre_write(i, {$urandom(), $urandom()} | 64'd1);
        pre_write(4, 64'h1111_1111_1111_1111);
        pre_write(5, 64'h2222_2222_2222_2222);
        pre_write(6, 64'h3333_3333_3333_3333);
        pre_write(7, 64'h4444_4444_4444_4444);

        // Directed scenarios
        run_burst(BASE + 32'h20, 8'd3, 2'b01, 0, -1, 0, 64'd0);
        run_burst(BASE + 32'h20, 8'd3, 2'b01, 1, -1, 0, 64'd0);
        run_burst(BASE + 32'h30, 8'd3, 2'b10, 0, -1, 0, 64'd0);
        run_burst(BASE - 32'h8, 8'd1, 2'b01, 0, -1, 0, 64'd0);
        run_burst(BASE - 32'h8, 8'd1, 2'b00, 0, -1, 0, 64'd0);
        run_burst(BASE + 32'((MEM_DP - 1) * 8), 8'd1, 2'b01, 0, -1, 0, 64'd0);
        run_burst(BASE + 32'h8, 8'd2, 2'b00, 0, 0, 1, 64'h0000_0000_0000_DEAD);
        run_burst(BASE + 32'h10, 8'd0, 2'b11, 0, -1, 0, 64'd0);
        run_burst(BASE + 32'h3C, 8'd7, 2'b10, 2, -1, 0, 64'd0);

        // Reset in the middle of a burst
        S_ARADDR = BASE + 32'h10; S_ARLEN = 8'd3; S_ARBURST = 2'b01; S_ARVALID = 1'b1;
        @(posedge CLK); #1;
        S_ARVALID = 1'b0;
        cyc = 0;
        while (S_RVALID !== 1'b1 && cyc < 40) begin @(posedge CLK); #1; cyc++; end
        check_val("rst_test_rvalid", 64'(S_RVALID), 64'd1);
        S_RREADY = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        S_RREADY = 1'b0;
        check_val("rst_test_beat2", S_RDATA, shadow[4]);
        #2 RST = 1'b1;
        #1;
        check_val("midrst_rvalid", 64'(S_RVALID), 64'd0);
        check_val("midrst_rlast", 64'(S_RLAST), 64'd0);
        check_val("midrst_rdata", S_RDATA, 64'd0);
        check_val("midrst_arready", 64'(S_ARREADY), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        check_val("midrst_arready_hold", 64'(S_ARREADY), 64'd0);
        @(posedge CLK); #1;
        check_val("midrst_arready_up", 64'(S_ARREADY), 64'd1);
        run_burst(BASE + 32'h18, 8'd0, 2'b01, 0, -1, 0, 64'd0);

        // Randomized bursts with occasional preloads while idle or mid-burst
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) pre_write(int'($urandom_range(0, MEM_DP - 1)), {$urandom(), $urandom()});
            ra = BASE - 32'd64 + 32'($urandom_range(0, MEM_DP * 8 + 128));
            rl = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 15));
            pb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
            run_burst(ra, rl, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), pb,
                      int'($urandom_range(0, MEM_DP - 1)), {$urandom(), $urandom()});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
